// File: rtl/adc_ctrl_pkg.sv
// Shared definitions for the ADC receiver control blocks: tap/window widths,
// calibration state encoding and the window-centre helper.
package adc_ctrl_pkg;

  localparam int TAP_W    = 5;
  localparam int WIN_W    = 6;
  localparam int SRST_CYC = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SRST,
    ST_SET,
    ST_SETTLE,
    ST_CHECK,
    ST_EVAL,
    ST_FINISH
  } cal_state_t;

  // Centre tap of a window, rounding towards the window start.
  // A window never runs past tap 31, so the sum always fits in TAP_W bits.
  function automatic logic [TAP_W-1:0] win_center(input logic [TAP_W-1:0] start,
                                                  input logic [WIN_W-1:0] len);
    logic [WIN_W-1:0] sum;
    sum = {1'b0, start} + ((len - WIN_W'(1)) >> 1);
    return sum[TAP_W-1:0];
  endfunction

endpackage

// File: rtl/adc_win_track.sv
// Tracks the current run of passing taps and keeps the longest one seen.
// A later run must be strictly longer to displace an earlier one.
module adc_win_track
  import adc_ctrl_pkg::*;
(
  input  logic             CLK_DIV_IN,
  input  logic             IO_RESET,
  input  logic             valid,
  input  logic             pass,
  input  logic [TAP_W-1:0] tap,
  input  logic             clear,
  output logic [TAP_W-1:0] best_start,
  output logic [WIN_W-1:0] best_len
);

  logic [TAP_W-1:0] cur_start;
  logic [WIN_W-1:0] cur_len;
  logic [WIN_W-1:0] next_len;
  logic [TAP_W-1:0] next_start;

  assign next_len   = cur_len + WIN_W'(1);
  assign next_start = (cur_len == '0) ? tap : cur_start;

  always_ff @(posedge CLK_DIV_IN or posedge IO_RESET) begin
    if (IO_RESET) begin
      cur_start  <= '0;
      cur_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
    end else if (clear) begin
      cur_start  <= '0;
      cur_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
    end else if (valid) begin
      if (pass) begin
        cur_start <= next_start;
        cur_len   <= next_len;
        if (next_len > best_len) begin
          best_start <= next_start;
          best_len   <= next_len;
        end
      end else begin
        cur_len <= '0;
      end
    end
  end

endmodule

// File: rtl/adc_tap_calib.sv
// Input-delay tap sweep for a single ADC lane: scores every tap against the
// ADC test pattern and parks the delay in the centre of the widest clean window.
//
// state  | meaning
// IDLE   | waiting for START, results held
// SRST   | ISERDES held in reset for SRST_CYC cycles
// SET    | new tap presented on TAP_OUT
// SETTLE | minimum settle time plus wait for TAP_MON to echo TAP_OUT
// CHECK  | CHECK_CYC samples compared against PATTERN, no early exit
// EVAL   | tap verdict folded into the window tracker
// FINISH | centre tap applied, DONE or FAIL raised
module adc_tap_calib
  import adc_ctrl_pkg::*;
#(
  parameter logic [15:0] PATTERN    = 16'hA55A,
  parameter int          SETTLE_CYC = 8,
  parameter int          CHECK_CYC  = 64,
  parameter int          MIN_WIN    = 4
) (
  input  logic             CLK_DIV_IN,
  input  logic             IO_RESET,
  input  logic             START,
  input  logic [15:0]      ADC_DATA,
  input  logic [TAP_W-1:0] TAP_MON,
  output logic [TAP_W-1:0] TAP_OUT,
  output logic             SERDES_RST,
  output logic             BUSY,
  output logic             DONE,
  output logic             FAIL,
  output logic [TAP_W-1:0] WIN_START,
  output logic [WIN_W-1:0] WIN_LEN
);

  localparam int               CNT_W     = 10;
  localparam logic [CNT_W-1:0] SRST_LD   = CNT_W'(SRST_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CHECK_LD  = CNT_W'(CHECK_CYC - 1);
  localparam logic [WIN_W-1:0] MIN_WIN_V = WIN_W'(MIN_WIN);
  localparam logic [TAP_W-1:0] TAP_LAST  = '1;

  cal_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [TAP_W-1:0] tap_idx;
  logic             tap_ok;
  logic             win_valid;
  logic             win_clear;
  logic [TAP_W-1:0] best_start;
  logic [WIN_W-1:0] best_len;

  assign win_valid = (state == ST_EVAL);
  assign win_clear = (state == ST_IDLE) && START;

  adc_win_track u_win_track (
    .CLK_DIV_IN (CLK_DIV_IN),
    .IO_RESET   (IO_RESET),
    .valid      (win_valid),
    .pass       (tap_ok),
    .tap        (tap_idx),
    .clear      (win_clear),
    .best_start (best_start),
    .best_len   (best_len)
  );

  always_ff @(posedge CLK_DIV_IN or posedge IO_RESET) begin
    if (IO_RESET) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      tap_idx    <= '0;
      tap_ok     <= 1'b0;
      TAP_OUT    <= '0;
      SERDES_RST <= 1'b1;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      FAIL       <= 1'b0;
      WIN_START  <= '0;
      WIN_LEN    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          SERDES_RST <= 1'b0;
          if (START) begin
            DONE       <= 1'b0;
            FAIL       <= 1'b0;
            WIN_START  <= '0;
            WIN_LEN    <= '0;
            tap_idx    <= '0;
            BUSY       <= 1'b1;
            SERDES_RST <= 1'b1;
            cnt        <= SRST_LD;
            state      <= ST_SRST;
          end
        end
        ST_SRST: begin
          if (cnt == '0) begin
            SERDES_RST <= 1'b0;
            tap_idx    <= '0;
            TAP_OUT    <= '0;
            state      <= ST_SET;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_SET: begin
          cnt   <= SETTLE_LD;
          state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          // Settle time is a floor; a slow receiver stretches it via TAP_MON.
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (TAP_MON == TAP_OUT) begin
            cnt    <= CHECK_LD;
            tap_ok <= 1'b1;
            state  <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          tap_ok <= tap_ok & (ADC_DATA == PATTERN);
          if (cnt == '0) begin
            state <= ST_EVAL;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_EVAL: begin
          if (tap_idx == TAP_LAST) begin
            state <= ST_FINISH;
          end else begin
            tap_idx <= tap_idx + TAP_W'(1);
            TAP_OUT <= tap_idx + TAP_W'(1);
            state   <= ST_SET;
          end
        end
        ST_FINISH: begin
          WIN_START <= best_start;
          WIN_LEN   <= best_len;
          BUSY      <= 1'b0;
          state     <= ST_IDLE;
          if (best_len >= MIN_WIN_V) begin
            TAP_OUT <= win_center(best_start, best_len);
            DONE    <= 1'b1;
          end else begin
            TAP_OUT <= '0;
            FAIL    <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_tap_calib.sv
// Bench for adc_tap_calib: an ADC model emits the pattern only on chosen taps,
// expected results are queued at START and compared when DONE or FAIL rises.
module tb_adc_tap_calib;

  localparam logic [15:0] PATTERN = 16'hA55A;
  localparam int          MIN_WIN = 4;

  logic        clk        = 1'b0;
  logic        io_reset   = 1'b0;
  logic        start      = 1'b0;
  logic [15:0] adc_data   = 16'h0000;
  logic [4:0]  tap_mon;
  logic [4:0]  tap_out;
  logic        serdes_rst;
  logic        busy;
  logic        done;
  logic        fail;
  logic [4:0]  win_start;
  logic [5:0]  win_len;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] pass_mask = 32'h0;
  int          bad_tap   = -1;
  int          bad_age   = -1;
  int          lag       = 0;
  int          last_tap  = -1;
  int          age       = 0;
  logic [4:0]  hist [32] = '{default: 5'd0};

  typedef struct {
    int         start_cyc;
    int         exp_cyc;
    logic       done;
    logic       fail;
    logic [4:0] ws;
    logic [5:0] wl;
    logic [4:0] tap;
  } exp_t;

  exp_t sb[$];

  adc_tap_calib #(
    .PATTERN    (PATTERN),
    .SETTLE_CYC (8),
    .CHECK_CYC  (64),
    .MIN_WIN    (MIN_WIN)
  ) dut (
    .CLK_DIV_IN (clk),
    .IO_RESET   (io_reset),
    .START      (start),
    .ADC_DATA   (adc_data),
    .TAP_MON    (tap_mon),
    .TAP_OUT    (tap_out),
    .SERDES_RST (serdes_rst),
    .BUSY       (busy),
    .DONE       (done),
    .FAIL       (fail),
    .WIN_START  (win_start),
    .WIN_LEN    (win_len)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign tap_mon = (lag == 0) ? tap_out : hist[lag];

  // ADC and delay-line model: age counts cycles since TAP_OUT last changed.
  always @(negedge clk) begin
    if (int'(tap_out) != last_tap) begin
      last_tap = int'(tap_out);
      age = 0;
    end else begin
      age++;
    end
    for (int i = 31; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = tap_out;
    if (pass_mask[tap_out] && !(int'(tap_out) == bad_tap && age == bad_age))
      adc_data = PATTERN;
    else
      adc_data = ~PATTERN;
  end

  logic prev_res = 1'b0;
  always @(posedge clk) begin : monitor
    exp_t e;
    int   n;
    #1;
    if ((done | fail) === 1'b1 && !prev_res) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result done=%0b fail=%0b required no result", done, fail);
      end else begin
        e = sb.pop_front();
        if (done !== e.done || fail !== e.fail) begin
          errors++;
          $display("FAIL done_fail got %0b/%0b required %0b/%0b", done, fail, e.done, e.fail);
        end
        checks++;
        if (win_start !== e.ws) begin
          errors++;
          $display("FAIL win_start got %0d required %0d", win_start, e.ws);
        end
        checks++;
        if (win_len !== e.wl) begin
          errors++;
          $display("FAIL win_len got %0d required %0d", win_len, e.wl);
        end
        checks++;
        if (tap_out !== e.tap) begin
          errors++;
          $display("FAIL tap_out got %0d required %0d", tap_out, e.tap);
        end
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_at_end got %0b required 0", busy);
        end
        n = cyc - e.start_cyc + 1;
        if (e.exp_cyc > 0) begin
          checks++;
          if (n != e.exp_cyc) begin
            errors++;
            $display("FAIL run_cycles got %0d required %0d", n, e.exp_cyc);
          end
        end
      end
    end
    prev_res = ((done | fail) === 1'b1);
  end

  task automatic start_run(input logic [31:0] drive_mask, input logic [31:0] model_mask,
                           input int exp_cyc);
    exp_t e;
    int bs, bl, cs, cl;
    bs = 0; bl = 0; cs = 0; cl = 0;
    for (int t = 0; t < 32; t++) begin
      if (model_mask[t]) begin
        if (cl == 0) cs = t;
        cl++;
        if (cl > bl) begin
          bl = cl;
          bs = cs;
        end
      end else begin
        cl = 0;
      end
    end
    e.done    = (bl >= MIN_WIN);
    e.fail    = !(bl >= MIN_WIN);
    e.ws      = 5'(bs);
    e.wl      = 6'(bl);
    e.tap     = (bl >= MIN_WIN) ? 5'(bs + (bl - 1) / 2) : 5'd0;
    e.exp_cyc = exp_cyc;
    pass_mask = drive_mask;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.start_cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_result(input string name, input int limit);
    int i;
    i = 0;
    while (sb.size() != 0 && i < limit) begin
      @(posedge clk);
      i++;
    end
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout pending %0d required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    #1 io_reset = 1'b1;
    #3;
    checks++;
    if ({tap_out, serdes_rst, busy, done, fail} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_ctrl got %0h/%0b/%0b/%0b/%0b required 0/1/0/0/0",
               tap_out, serdes_rst, busy, done, fail);
    end
    checks++;
    if ({win_start, win_len} !== 11'd0) begin
      errors++;
      $display("FAIL reset_win got %0d/%0d required 0/0", win_start, win_len);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    io_reset = 1'b0;
    #1;
    checks++;
    if (serdes_rst !== 1'b1) begin
      errors++;
      $display("FAIL serdes_hold got %0b required 1", serdes_rst);
    end
    @(posedge clk);
    #1;
    checks++;
    if (serdes_rst !== 1'b0) begin
      errors++;
      $display("FAIL serdes_release got %0b required 0", serdes_rst);
    end
  endtask

  task automatic test_window_10_17();
    int hi;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_idle got %0b required 0", busy);
    end
    start_run(32'h0003FC00, 32'h0003FC00, 2374);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_rise got %0b required 1", busy);
    end
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      if (serdes_rst === 1'b1) hi++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (hi != 4) begin
      errors++;
      $display("FAIL serdes_rst_cycles got %0d required 4", hi);
    end
    wait_result("window_10_17", 3000);
  endtask

  task automatic test_two_windows();
    start_run(32'h0FF0003C, 32'h0FF0003C, 2374);
    wait_result("two_windows", 3000);
  endtask

  task automatic test_tie();
    start_run(32'h0FF003FC, 32'h0FF003FC, 2374);
    wait_result("tie", 3000);
  endtask

  task automatic test_full();
    start_run(32'hFFFFFFFF, 32'hFFFFFFFF, 2374);
    wait_result("full", 3000);
  endtask

  task automatic test_too_narrow();
    start_run(32'h00000700, 32'h00000700, 2374);
    wait_result("too_narrow", 3000);
  endtask

  task automatic test_late_mismatch();
    bad_tap = 12;
    bad_age = 72;
    start_run(32'h0003FC00, 32'h0003EC00, 2374);
    wait_result("late_mismatch", 3000);
    bad_tap = -1;
    bad_age = -1;
  endtask

  task automatic test_tap_lag();
    lag = 20;
    start_run(32'h0003FC00, 32'h0003FC00, 1 + 4 + 32 * 86 + 1);
    wait_result("tap_lag", 4000);
    lag = 0;
  endtask

  task automatic test_reset_abort();
    int i;
    start_run(32'h0003FC00, 32'h0003FC00, 2374);
    i = 0;
    while (tap_out !== 5'd9 && i < 2000) begin
      @(posedge clk);
      #1;
      i++;
    end
    checks++;
    if (tap_out !== 5'd9) begin
      errors++;
      $display("FAIL reach_tap9 got %0d required 9", tap_out);
    end
    repeat (20) @(posedge clk);
    #2 io_reset = 1'b1;
    #1;
    checks++;
    if ({tap_out, serdes_rst, busy, done, fail, win_start, win_len}
        !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 6'd0}) begin
      errors++;
      $display("FAIL abort_outputs got %0d/%0b/%0b/%0b/%0b/%0d/%0d required 0/1/0/0/0/0/0",
               tap_out, serdes_rst, busy, done, fail, win_start, win_len);
    end
    sb.delete();
    @(negedge clk);
    io_reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (serdes_rst !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_release got %0b/%0b required 0/0", serdes_rst, busy);
    end
    repeat (200) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, fail, tap_out} !== {1'b0, 1'b0, 1'b0, 5'd0}) begin
      errors++;
      $display("FAIL abort_idle got %0b/%0b/%0b/%0d required 0/0/0/0", busy, done, fail, tap_out);
    end
  endtask

  task automatic test_back_to_back();
    start_run(32'h0000007F, 32'h0000007F, 2374);
    repeat (100) @(posedge clk);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (1500) @(posedge clk);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_ignored got busy=%0b done=%0b required 1/0", busy, done);
    end
    wait_result("b2b_first", 3000);
    start_run(32'hFE000000, 32'hFE000000, 2374);
    wait_result("b2b_second", 3000);
  endtask

  initial begin
    test_reset();
    test_window_10_17();
    test_two_windows();
    test_tie();
    test_full();
    test_too_narrow();
    test_late_mismatch();
    test_tap_lag();
    test_reset_abort();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired required completion");
    $fatal(1, "watchdog");
  end

endmodule
